cp0_int_ctrl: RTL and testbench

//  Coprocessor-0 exception/interrupt controller in the M stage.

---
 rtl/cp0_int_ctrl_pkg.sv | 38 +++
 rtl/cp0_int_ctrl_if.sv | 28 ++
 rtl/cp0_int_ctrl_arb.sv | 22 ++
 rtl/cp0_int_ctrl.sv | 134 +++++++++++++
 tb/tb_cp0_int_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_int_ctrl_pkg.sv
// cp0_pkg: shared constants for the CP0 exception/interrupt controller.
// Register numbers, ExcCode values, SR/Cause field positions and the
// handler entry address exported to the next-PC logic.
package cp0_pkg;

  localparam int INT_NUM = 6;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = SR_IM_LO + INT_NUM - 1;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = CAUSE_IP_LO + INT_NUM - 1;
  localparam int CAUSE_BD     = 31;

  // EXL doubles as the controller state: outside or inside a handler.
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exl_state_e;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// cp0_int_ctrl_if: M-stage pipeline-side bundle of the CP0 controller.
// The pipeline is the master; the controller connects through the slave modport.
interface cp0_int_ctrl_if;
  import cp0_pkg::*;

  logic [4:0]         cp0_addr;
  logic               cp0_we;
  logic [31:0]        cp0_wdata;
  logic [31:0]        pc_m;
  logic               bd_m;
  logic [4:0]         exc_code_m;
  logic [INT_NUM-1:0] hw_int;
  logic               eret_m;
  logic [31:0]        cp0_rdata;
  logic [31:0]        epc_out;
  logic               int_req;

  modport master (
    output cp0_addr, cp0_we, cp0_wdata, pc_m, bd_m, exc_code_m, hw_int, eret_m,
    input  cp0_rdata, epc_out, int_req
  );

  modport slave (
    input  cp0_addr, cp0_we, cp0_wdata, pc_m, bd_m, exc_code_m, hw_int, eret_m,
    output cp0_rdata, epc_out, int_req
  );

endinterface

// File: rtl/cp0_int_ctrl_arb.sv
// cp0_int_arb: combinational interrupt masking and exception priority.
// Interrupts win over M-stage exceptions; eret and EXL block everything.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic [INT_NUM-1:0] hw_int_i,
  input  logic [INT_NUM-1:0] sr_im_i,
  input  logic               sr_ie_i,
  input  logic               sr_exl_i,
  input  logic               eret_i,
  input  logic [4:0]         exc_code_i,
  output logic               int_req_o,
  output logic [4:0]         exc_sel_o
);

  logic irq;

  assign irq       = (|(hw_int_i & sr_im_i)) & sr_ie_i & ~sr_exl_i;
  assign int_req_o = ~eret_i & ~sr_exl_i & (irq | (exc_code_i != 5'd0));
  assign exc_sel_o = irq ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: CP0 SR/Cause/EPC/PRId registers, mtc0 write path, mfc0 read
// mux and eret EPC bypass. Optional macro CP0_BD_EN enables branch-delay
// tracking (Cause.BD and EPC rewound to the branch).
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2021_0707
) (
  input  logic           clk,
  input  logic           reset,
  cp0_int_ctrl_if.slave  bus
);

  exl_state_e         state_q, state_d;
  logic [INT_NUM-1:0] im_q, im_d;
  logic               ie_q, ie_d;
  logic [INT_NUM-1:0] ip_q;
  logic [4:0]         exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        epc_src;
  logic               cause_bd;
  logic               exl;
  logic               int_req;
  logic [4:0]         exc_sel;
  logic               sr_wr;
  logic               epc_wr;
  logic [31:0]        rdata;
  logic               unused_bits;

  assign exl = (state_q == ST_HANDLER);

  cp0_int_arb u_arb (
    .hw_int_i   (bus.hw_int),
    .sr_im_i    (im_q),
    .sr_ie_i    (ie_q),
    .sr_exl_i   (exl),
    .eret_i     (bus.eret_m),
    .exc_code_i (bus.exc_code_m),
    .int_req_o  (int_req),
    .exc_sel_o  (exc_sel)
  );

  // A faulting instruction must not commit its mtc0.
  assign sr_wr  = bus.cp0_we & ~int_req & (bus.cp0_addr == REG_SR);
  assign epc_wr = bus.cp0_we & ~int_req & (bus.cp0_addr == REG_EPC);

`ifdef CP0_BD_EN
  logic bd_q;

  assign epc_src  = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
  assign cause_bd = bd_q;

  // Cause.BD latches the delay-slot flag of the excepting instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bd_q <= 1'b0;
    else if (int_req) bd_q <= bus.bd_m;
  end
`else
  logic unused_bd_m;

  assign epc_src     = bus.pc_m;
  assign cause_bd    = 1'b0;
  assign unused_bd_m = bus.bd_m;
`endif

  assign unused_bits = ^{epc_src[1:0], bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

  // Next-state: exception entry has priority over mtc0 writes and eret.
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    if (int_req) begin
      state_d = ST_HANDLER;
      exc_d   = exc_sel;
      epc_d   = {epc_src[31:2], 2'b00};
    end else begin
      if (sr_wr) begin
        im_d    = bus.cp0_wdata[SR_IM_HI:SR_IM_LO];
        ie_d    = bus.cp0_wdata[SR_IE];
        state_d = exl_state_e'(bus.cp0_wdata[SR_EXL]);
      end
      if (epc_wr) epc_d = bus.cp0_wdata;
      if (bus.eret_m) state_d = ST_NORMAL;
    end
  end

  // Architectural register update; Cause.IP samples the raw lines every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_NORMAL;
      im_q    <= '0;
      ie_q    <= 1'b0;
      ip_q    <= '0;
      exc_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      ip_q    <= bus.hw_int;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux; unimplemented fields and addresses read as zero.
  always_comb begin
    rdata = '0;
    case (bus.cp0_addr)
      REG_SR: begin
        rdata[SR_IM_HI:SR_IM_LO] = im_q;
        rdata[SR_EXL]            = exl;
        rdata[SR_IE]             = ie_q;
      end
      REG_CAUSE: begin
        rdata[CAUSE_BD]                  = cause_bd;
        rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
        rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
      end
      REG_EPC:  rdata = epc_q;
      REG_PRID: rdata = PRID;
      default:  rdata = '0;
    endcase
  end

  assign bus.cp0_rdata = rdata;
  assign bus.int_req   = int_req;
  // An mtc0 EPC in flight alongside eret must redirect to the new value.
  assign bus.epc_out   = (bus.cp0_we && bus.cp0_addr == REG_EPC) ? bus.cp0_wdata : epc_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Testbench for cp0_int_ctrl: scenario tasks with a queue of expected values.
module tb_cp0_int_ctrl;
  import cp0_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_int_ctrl_if bus();

  cp0_int_ctrl #(.PRID(32'h2021_0707)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs;
  int          n_chk  = 0;
  int          n_fail = 0;

`ifdef CP0_BD_EN
  localparam logic [31:0] EXP_EXC_EPC   = 32'h0000_3004;
  localparam logic [31:0] EXP_EXC_CAUSE = 32'h8000_0030;
`else
  localparam logic [31:0] EXP_EXC_EPC   = 32'h0000_3008;
  localparam logic [31:0] EXP_EXC_CAUSE = 32'h0000_0030;
`endif

  task automatic push(input string nm, input logic [31:0] v);
    exp_t x;
    x.name = nm;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic idle();
    bus.cp0_we     = 1'b0;
    bus.cp0_wdata  = '0;
    bus.eret_m     = 1'b0;
    bus.exc_code_m = '0;
    bus.bd_m       = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_we   = 1'b0;
    bus.cp0_addr = a;
    #1;
    d = bus.cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = a;
    bus.cp0_wdata = d;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    bus.cp0_addr = '0;
    bus.pc_m     = '0;
    bus.hw_int   = '0;
    reset        = 1'b1;
    #12;
    push("reset_sr", 32'h0); push("reset_cause", 32'h0); push("reset_epc", 32'h0);
    push("reset_prid", 32'h2021_0707); push("reset_int_req", 32'h0); push("reset_epc_out", 32'h0);
    rd(REG_SR, obs);    e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_CAUSE, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_EPC, obs);   e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_PRID, obs);  e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    obs = bus.epc_out;      e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_interrupt();
    mtc0(REG_SR, 32'h0000_fc01);
    @(negedge clk);
    bus.hw_int = 6'b000100;
    bus.pc_m   = 32'h0000_2000;
    push("irq_int_req", 32'h1);
    #1;
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(posedge clk);
    #1;
    idle();
    push("irq_sr", 32'h0000_fc03); push("irq_cause", 32'h0000_1000); push("irq_epc", 32'h0000_2000);
    rd(REG_SR, obs);    e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_CAUSE, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_EPC, obs);   e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(negedge clk);
    bus.hw_int = '0;
    bus.eret_m = 1'b1;
    push("eret_int_req", 32'h0);
    #1;
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(posedge clk);
    #1;
    idle();
    push("eret_sr", 32'h0000_fc01);
    rd(REG_SR, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_exception();
    mtc0(REG_SR, 32'h0);
    @(negedge clk);
    bus.exc_code_m = EXC_OV;
    bus.pc_m       = 32'h0000_3008;
    bus.bd_m       = 1'b1;
    push("exc_int_req", 32'h1);
    #1;
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(posedge clk);
    #1;
    idle();
    push("exc_epc", EXP_EXC_EPC); push("exc_cause", EXP_EXC_CAUSE); push("exc_sr", 32'h0000_0002);
    rd(REG_EPC, obs);   e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_CAUSE, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_SR, obs);    e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_exl_masking();
    @(negedge clk);
    bus.hw_int     = 6'h3f;
    bus.exc_code_m = EXC_ADEL;
    push("exl_int_req_a", 32'h0);
    #1;
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(posedge clk);
    #1;
    push("exl_int_req_b", 32'h0);
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    idle();
    push("exl_cause", EXP_EXC_CAUSE | 32'h0000_fc00); push("exl_epc", EXP_EXC_EPC);
    rd(REG_CAUSE, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_EPC, obs);   e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_eret_bypass();
    @(negedge clk);
    bus.hw_int    = '0;
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = REG_EPC;
    bus.cp0_wdata = 32'h0000_3100;
    bus.eret_m    = 1'b1;
    push("byp_epc_out", 32'h0000_3100); push("byp_int_req", 32'h0);
    #1;
    obs = bus.epc_out;      e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(posedge clk);
    #1;
    idle();
    push("byp_sr", 32'h0); push("byp_epc", 32'h0000_3100);
    rd(REG_SR, obs);  e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_EPC, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_mtc0_drop();
    mtc0(REG_SR, 32'h0000_fc01);
    @(negedge clk);
    bus.hw_int     = 6'b000001;
    bus.exc_code_m = EXC_RI;
    bus.pc_m       = 32'h0000_5000;
    bus.cp0_we     = 1'b1;
    bus.cp0_addr   = REG_SR;
    bus.cp0_wdata  = 32'h0;
    push("drop_int_req", 32'h1);
    #1;
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(posedge clk);
    #1;
    idle();
    push("drop_sr", 32'h0000_fc03); push("drop_cause", 32'h0000_0400); push("drop_epc", 32'h0000_5000);
    rd(REG_SR, obs);    e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_CAUSE, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_EPC, obs);   e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    mtc0(REG_CAUSE, 32'hffff_ffff);
    push("cause_wr_ignored", 32'h0000_0400);
    rd(REG_CAUSE, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
  endtask

  task automatic test_reset_mid_handler();
    mtc0(REG_EPC, 32'h0000_4000);
    push("mid_epc", 32'h0000_4000); push("mid_sr", 32'h0000_fc03);
    rd(REG_EPC, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_SR, obs);  e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #0.5;
    push("rst_sr", 32'h0); push("rst_epc", 32'h0); push("rst_epc_out", 32'h0); push("rst_int_req", 32'h0);
    rd(REG_SR, obs);  e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    rd(REG_EPC, obs); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    obs = bus.epc_out;      e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    obs = 32'(bus.int_req); e = sb.pop_front(); n_chk++;
    if (obs !== e.val) begin n_fail++; $display("FAIL %s: got %h, expected %h", e.name, obs, e.val); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_exl_masking();
    test_eret_bypass();
    test_mtc0_drop();
    test_reset_mid_handler();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
